// File: rtl/control_fsm_pkg.sv
// control_fsm_pkg
// Shared definitions for the multicycle RISC-V control unit: the main-FSM
// state encoding (also used by the downstream control-signal decoder), the
// opcode and funct3 constants recognised in DECODE, and a helper that
// identifies retiring transitions into FETCH.
package control_fsm_pkg;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADR   = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXECUTE_R = 4'd6,
    ALU_WB    = 4'd7,
    EXECUTE_I = 4'd8,
    BNEZ      = 4'd9
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] FUNCT3_BNE = 3'b001;

  // An instruction retires on the edge that returns the machine to FETCH
  // after completing its work. MEM_WRITE only completes once memory
  // accepts the store; illegal-opcode and unused-code exits never retire.
  function automatic logic isRetiring(input logic [3:0] state, input logic memReady);
    case (state)
      MEM_WB, ALU_WB, BNEZ: isRetiring = 1'b1;
      MEM_WRITE:            isRetiring = memReady;
      default:              isRetiring = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/control_fsm_next_state.sv
// control_next_state
// Pure combinational next-state function of the main control FSM.
// Ports:
//   state_i     current FSM state (unused codes 10-15 fall back to FETCH)
//   opcode_i    instruction opcode bits [6:0]
//   funct3_i    instruction funct3 bits [14:12]
//   memReady_i  memory completes its access this cycle
//   nextState_o state to load on the next rising clock edge
//   illegal_o   DECODE saw an opcode this machine cannot execute
module control_next_state
  import control_fsm_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       memReady_i,
  output logic [3:0] nextState_o,
  output logic       illegal_o
);

  // Memory-facing states hold until memReady_i; everything else advances
  // unconditionally. Any unrecognised state code recovers to FETCH.
  always_comb begin
    nextState_o = FETCH;
    illegal_o   = 1'b0;
    case (state_i)
      FETCH:     nextState_o = memReady_i ? DECODE : FETCH;
      DECODE: begin
        if (opcode_i == OP_LOAD || opcode_i == OP_STORE) begin
          nextState_o = MEM_ADR;
        end else if (opcode_i == OP_R) begin
          nextState_o = EXECUTE_R;
        end else if (opcode_i == OP_I) begin
          nextState_o = EXECUTE_I;
        end else if (opcode_i == OP_BRANCH && funct3_i == FUNCT3_BNE) begin
          nextState_o = BNEZ;
        end else begin
          nextState_o = FETCH;
          illegal_o   = 1'b1;
        end
      end
      MEM_ADR:   nextState_o = (opcode_i == OP_LOAD) ? MEM_READ : MEM_WRITE;
      MEM_READ:  nextState_o = memReady_i ? MEM_WB : MEM_READ;
      MEM_WRITE: nextState_o = memReady_i ? FETCH : MEM_WRITE;
      EXECUTE_R: nextState_o = ALU_WB;
      EXECUTE_I: nextState_o = ALU_WB;
      default:   nextState_o = FETCH;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// control_fsm
// Sequencing core of the multicycle RISC-V control unit. Holds the main-FSM
// state register, a sticky illegal-instruction flag and a retired-instruction
// counter.
// Ports:
//   clk          sole clock, rising edge
//   reset        synchronous, active-high
//   opcode       instruction bits [6:0], valid from DECODE onward
//   funct3       instruction bits [14:12]
//   zero         ALU zero flag, meaningful during BNEZ
//   mem_ready    memory completes the current access this cycle
//   curr_state   registered FSM state, drives the control decoder
//   branch_taken BNEZ with a non-zero operand (combinational)
//   illegal      sticky illegal-opcode flag, cleared only by reset
//   instret      retired-instruction count, wraps modulo 2^INSTRET_W
module control_fsm
  import control_fsm_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic [3:0]           curr_state,
  output logic                 branch_taken,
  output logic                 illegal,
  output logic [INSTRET_W-1:0] instret
);

  logic [3:0]           state_q;
  logic [3:0]           state_d;
  logic                 illegalDetect;
  logic                 retire;
  logic                 illegal_q;
  logic                 illegal_d;
  logic [INSTRET_W-1:0] instret_q;
  logic [INSTRET_W-1:0] instret_d;

  control_next_state u_nextState (
    .state_i     (state_q),
    .opcode_i    (opcode),
    .funct3_i    (funct3),
    .memReady_i  (mem_ready),
    .nextState_o (state_d),
    .illegal_o   (illegalDetect)
  );

  // Flag and counter updates are computed alongside the state transition so
  // that they land on the same edge that enters FETCH.
  always_comb begin
    retire    = isRetiring(state_q, mem_ready);
    illegal_d = illegal_q | illegalDetect;
    instret_d = retire ? instret_q + 1'b1 : instret_q;
  end

  // State register plus the sticky flag and counter; reset overrides any
  // in-flight instruction or memory stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      instret_q <= instret_d;
    end
  end

  // Output decode: branch_taken is the only combinational output and
  // reflects the zero flag in the same cycle.
  always_comb begin
    curr_state   = state_q;
    branch_taken = (state_q == BNEZ) && !zero;
    illegal      = illegal_q;
    instret      = instret_q;
  end

endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm
// Self-checking bench for control_fsm. Instructions are described as
// classes with stall counts; the expected per-cycle state trace, branch
// outcome, illegal flag and retire count are derived from the instruction
// class rather than from the FSM's transition logic.
module tb_control_fsm;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic [6:0]   opcode;
  logic [2:0]   funct3;
  logic         zero;
  logic         mem_ready;
  logic [3:0]   curr_state;
  logic         branch_taken;
  logic         illegal;
  logic [W-1:0] instret;

  int checks = 0;
  int errors = 0;

  logic         expIllegal;
  logic [W-1:0] expInstret;

  control_fsm #(.INSTRET_W(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .funct3       (funct3),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .curr_state   (curr_state),
    .branch_taken (branch_taken),
    .illegal      (illegal),
    .instret      (instret)
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // One clock cycle: drive inputs, check the cycle's outputs, then advance
  task automatic applyStimulus(input logic [3:0] expState, input logic mr, input logic z);
    mem_ready = mr;
    zero      = z;
    #1;
    checkOutput("state", curr_state, expState);
    checkOutput("branch_taken", branch_taken, (expState == 4'd9) && !z);
    checkOutput("illegal", illegal, expIllegal);
    checkOutput("instret", instret, expInstret);
    @(posedge clk);
    #1;
  endtask

  function automatic logic isLegal(input logic [6:0] op, input logic [2:0] f3);
    return (op == 7'b0000011) || (op == 7'b0100011) || (op == 7'b0110011) ||
           (op == 7'b0010011) || (op == 7'b1100011 && f3 == 3'b001);
  endfunction

  // kind: 0 lw, 1 sw, 2 R-type, 3 I-type, 4 bnez, 5 illegal (uses illOp)
  task automatic runInstr(input int kind, input int fetchStalls, input int memStalls,
                          input logic z, input logic [6:0] illOp, input logic [2:0] illF3);
    for (int i = 0; i < fetchStalls; i++) begin
      opcode = 7'($urandom);
      funct3 = 3'($urandom);
      applyStimulus(4'd0, 1'b0, 1'($urandom));
    end
    applyStimulus(4'd0, 1'b1, 1'($urandom));
    case (kind)
      0: begin opcode = 7'b0000011; funct3 = 3'b010; end
      1: begin opcode = 7'b0100011; funct3 = 3'b010; end
      2: begin opcode = 7'b0110011; funct3 = 3'($urandom); end
      3: begin opcode = 7'b0010011; funct3 = 3'($urandom); end
      4: begin opcode = 7'b1100011; funct3 = 3'b001; end
      default: begin opcode = illOp; funct3 = illF3; end
    endcase
    applyStimulus(4'd1, 1'($urandom), 1'($urandom));
    case (kind)
      0: begin
        applyStimulus(4'd2, 1'($urandom), 1'($urandom));
        for (int i = 0; i < memStalls; i++) applyStimulus(4'd3, 1'b0, 1'($urandom));
        applyStimulus(4'd3, 1'b1, 1'($urandom));
        applyStimulus(4'd4, 1'($urandom), 1'($urandom));
      end
      1: begin
        applyStimulus(4'd2, 1'($urandom), 1'($urandom));
        for (int i = 0; i < memStalls; i++) applyStimulus(4'd5, 1'b0, 1'($urandom));
        applyStimulus(4'd5, 1'b1, 1'($urandom));
      end
      2: begin
        applyStimulus(4'd6, 1'($urandom), 1'($urandom));
        applyStimulus(4'd7, 1'($urandom), 1'($urandom));
      end
      3: begin
        applyStimulus(4'd8, 1'($urandom), 1'($urandom));
        applyStimulus(4'd7, 1'($urandom), 1'($urandom));
      end
      4: applyStimulus(4'd9, 1'($urandom), z);
      default: ;
    endcase
    if (kind == 5) expIllegal = 1'b1;
    else           expInstret = expInstret + 1'b1;
  endtask

  task automatic doReset();
    reset     = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    reset      = 1'b0;
    expIllegal = 1'b0;
    expInstret = '0;
  endtask

  initial begin
    logic [6:0] op;
    logic [2:0] f3;
    int         kind;

    reset      = 1'b1;
    opcode     = '0;
    funct3     = '0;
    zero       = 1'b0;
    mem_ready  = 1'b1;
    expIllegal = 1'b0;
    expInstret = '0;
    @(posedge clk);
    doReset();

    // Directed sequences
    runInstr(0, 0, 0, 1'b0, 7'h00, 3'd0);
    runInstr(1, 0, 3, 1'b0, 7'h00, 3'd0);
    runInstr(4, 0, 0, 1'b0, 7'h00, 3'd0);
    runInstr(4, 0, 0, 1'b1, 7'h00, 3'd0);
    runInstr(5, 0, 0, 1'b0, 7'h7F, 3'd0);
    runInstr(2, 0, 0, 1'b0, 7'h00, 3'd0);
    for (int i = 0; i < 15; i++) runInstr(2, 0, 0, 1'b0, 7'h00, 3'd0);
    runInstr(5, 1, 0, 1'b0, 7'b1100011, 3'b000);

    // Randomised instruction stream
    for (int n = 0; n < 150; n++) begin
      kind = int'($urandom_range(0, 5));
      do begin
        op = 7'($urandom);
        f3 = 3'($urandom);
        if ($urandom_range(0, 3) == 0) op = 7'b1100011;
      end while (isLegal(op, f3));
      runInstr(kind, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
               1'($urandom), op, f3);
    end

    // Reset mid-stall in MEM_READ after illegal and retire history exist
    runInstr(5, 0, 0, 1'b0, 7'h7F, 3'd0);
    runInstr(2, 0, 0, 1'b0, 7'h00, 3'd0);
    applyStimulus(4'd0, 1'b1, 1'b0);
    opcode = 7'b0000011;
    applyStimulus(4'd1, 1'b1, 1'b0);
    applyStimulus(4'd2, 1'b1, 1'b0);
    mem_ready = 1'b0;
    #1;
    checkOutput("pre_reset_state", curr_state, 4'd3);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset      = 1'b0;
    expIllegal = 1'b0;
    expInstret = '0;
    applyStimulus(4'd0, 1'b0, 1'b0);
    runInstr(3, 0, 0, 1'b0, 7'h00, 3'd0);
    applyStimulus(4'd0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
